// File: rtl/booth_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mul_seq
//  Description : Sequential radix-4 Booth multiplier. Accepts an N-bit
//                multiplicand/multiplier pair (signed or unsigned), retires
//                two multiplier bits per clock and delivers the 2N-bit product
//                LAT = N/2+1 clocks after the accepting edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_seq #(
    parameter int N   = 32,
    parameter int LAT = N / 2 + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sgn,
    input  logic [N-1:0]     mcand,
    input  logic [N-1:0]     mlier,
    output logic [2*N-1:0]   prodt,
    output logic             valid,
    output logic             busy
);

    // Accumulator carries two guard bits above the N+2-bit extended
    // multiplicand so that +/-2M never overflows.
    localparam int c_AW = N + 4;
    // Working register: {accumulator, extended multiplier, Booth bit q[-1]}.
    localparam int c_RW = c_AW + (N + 2) + 1;
    localparam int c_CW = $clog2(LAT + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(LAT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_load;
    logic                w_step;
    logic                w_done;

    logic [N+1:0]        r_mc;
    logic [c_RW-1:0]     r_acc;
    logic [c_CW-1:0]     r_cnt;
    logic [2*N-1:0]      r_prodt;
    logic                r_valid;
    logic                r_busy;

    logic [N+1:0]        w_mc_ext;
    logic [N+1:0]        w_ml_ext;
    logic [c_AW-1:0]     w_m1;
    logic [c_AW-1:0]     w_m2;
    logic [c_AW-1:0]     w_addend;
    logic [c_RW-1:0]     w_acc_add;
    logic [c_RW-1:0]     w_acc_sh;

    // Operand extension: sign bit replicated only in two's-complement mode.
    assign w_mc_ext = {{2{sgn & mcand[N-1]}}, mcand};
    assign w_ml_ext = {{2{sgn & mlier[N-1]}}, mlier};

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Booth step: recode the low three bits, add the selected multiple of the
    // multiplicand to the accumulator, then shift the whole register right by
    // two with sign fill. After LAT steps {accumulator, multiplier field}
    // holds the full signed product of the extended operands.
    always_comb begin
        w_m1 = {{2{r_mc[N+1]}}, r_mc};
        w_m2 = {w_m1[c_AW-2:0], 1'b0};
        case (r_acc[2:0])
            3'b001, 3'b010: w_addend = w_m1;
            3'b011:         w_addend = w_m2;
            3'b100:         w_addend = -w_m2;
            3'b101, 3'b110: w_addend = -w_m1;
            default:        w_addend = '0;
        endcase
        w_acc_add = {r_acc[c_RW-1 -: c_AW] + w_addend, r_acc[N+2:0]};
        w_acc_sh  = $signed(w_acc_add) >>> 2;
    end

    // Datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_mc    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_prodt <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_load) begin
                r_mc   <= w_mc_ext;
                r_acc  <= {{c_AW{1'b0}}, w_ml_ext, 1'b0};
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (w_step) begin
                r_acc <= w_acc_sh;
                r_cnt <= r_cnt + c_CW'(1);
                if (w_done) begin
                    // Bit 0 is the Booth look-behind bit; the product starts at bit 1.
                    r_prodt <= w_acc_sh[2*N:1];
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                end
            end
        end
    end

    assign prodt = r_prodt;
    assign valid = r_valid;
    assign busy  = r_busy;

endmodule
`default_nettype wire

// File: doc/booth_mul_seq.md
BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand width (even, N >= 4).
REQ-002 The block SHALL have parameter LAT, fixed at N/2+1, giving the number of radix-4 iterations and the start-to-valid latency in clocks.
REQ-003 Port clock, input, 1, the single clock; every register updates on its rising edge.
REQ-004 Port reset, input, 1, reset; synchronous, active-high.
REQ-005 Port start, input, 1, request to begin a multiply; sampled only in IDLE.
REQ-006 Port sgn, input, 1, operand mode: 1 = both operands two's complement, 0 = both unsigned; sampled with start.
REQ-007 Port mcand, input, N, multiplicand; sampled with start.
REQ-008 Port mlier, input, N, multiplier; sampled with start.
REQ-009 Port prodt, output, 2N, registered product; holds its value between results.
REQ-010 Port valid, output, 1, registered one-cycle pulse marking a new prodt.
REQ-011 Port busy, output, 1, registered; high while a multiply is in progress.

Function
REQ-012 The FSM SHALL have two states, IDLE and CALC.
REQ-013 In IDLE, start=1 at edge t0 SHALL latch mcand, mlier and sgn, clear the partial-product accumulator and iteration counter, set busy=1 and enter CALC.
REQ-014 Operands SHALL be extended internally to N+2 bits: sign-extended when sgn=1, zero-extended when sgn=0.
REQ-015 Each CALC cycle SHALL do one radix-4 Booth step: recode 3 multiplier bits into a digit in {-2,-1,0,+1,+2}, add that multiple of the extended multiplicand to the accumulator, then shift arithmetic right by 2.
REQ-016 CALC SHALL do exactly LAT steps, on edges t0+1 through t0+LAT.
REQ-017 At edge t0+LAT, the block SHALL write the low 2N bits of the exact product to prodt, set valid=1, set busy=0 and return to IDLE.
REQ-018 The result SHALL be exact for every operand pair in both modes, including sgn=1 with both operands at the most negative value.
REQ-019 valid SHALL be high for exactly one cycle per completed multiply, and low at every other time.
REQ-020 A start while busy=1 SHALL be ignored; latched operands and progress SHALL not change.
REQ-021 Changes on mcand, mlier or sgn during CALC SHALL not affect the result.
REQ-022 A start in the cycle where valid=1 (state IDLE) SHALL be accepted, giving back-to-back multiplies with one result every LAT+1 clocks.
REQ-023 With start held high continuously, a new multiply SHALL begin on every edge at which the FSM is in IDLE.
REQ-024 prodt SHALL change only at the completion edge (REQ-017) or on reset.

Reset
REQ-025 While reset=1 at a rising edge, the block SHALL set state=IDLE, prodt=0, valid=0 and busy=0, and clear the counter and accumulator.
REQ-026 Reset SHALL take priority over start and over any CALC step.
REQ-027 Reset during CALC SHALL abort the multiply with no valid pulse; the first start after reset releases SHALL be accepted normally.

Verification
REQ-028 The bench SHALL cover these directed scenarios at N=32:
- Basic unsigned: sgn=0, mcand=13, mlier=5, start at t0 -> busy=1 from t0+1; at t0+17 valid=1 for one cycle and prodt=65; prodt stays 65 afterwards.
- Unsigned extremes: sgn=0, both operands 0xFFFFFFFF -> prodt=0xFFFFFFFE00000001. Then mcand=0xDDD85DDD, mlier=0xBBBBEEBB -> prodt equals their unsigned 64-bit product, checked against a reference model.
- Signed corners: sgn=1 with (0xFFFFFFFF, 0xFFFFFFFF) -> prodt=1; with (0x80000000, 0x80000000) -> prodt=0x4000000000000000; with (0x80000000, 1) -> prodt=0xFFFFFFFF80000000; with (0, 0x7FFFFFFF) -> prodt=0.
- Start while busy: second start at t0+5 with different operands -> ignored; a single valid at t0+17 carries the first operands' product.
- Back-to-back: start held high for 3 operation pairs -> valid pulses at t0+17, t0+35 and t0+53, each with the correct product.
- Reset mid-operation: reset=1 at t0+8 for one cycle -> prodt=0, busy=0, no valid pulse; next start completes normally after 17 clocks.
- Randomised: at least 10^4 random operands in both modes, plus N=8 and N=16 builds -> every prodt matches the reference model; latency always LAT.
